fc_layer: RTL

Fully connected layer stage that sits directly downstream of `pool_layer`. It consumes the pooled feature maps that `pool_layer` writes back to `CNNmemory`. It fetches the flattened input vector and each weight row through the existing `load_block`, computes one Q8.8 fixed-point dot product per output neuron with a serial MAC, and writes each saturated, optionally ReLU'd result back to memory. Its memory-side signals match `pool_layer`, so the top level muxes the two stages onto the same `load_block` and memory write path.

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/fc_mac.sv | 58 +++++
 rtl/fc_layer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: Q8.8 data format, fully connected FSM states and
// the accumulator-to-word saturation helper.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = 40;

    typedef enum logic [2:0] {
        FC_IDLE     = 3'd0,
        FC_LOAD_IN  = 3'd1,
        FC_CAPTURE  = 3'd2,
        FC_LOAD_ROW = 3'd3,
        FC_MAC      = 3'd4,
        FC_WRITE    = 3'd5,
        FC_NEXT     = 3'd6,
        FC_FINISH   = 3'd7
    } fc_state_t;

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
        logic signed [DATA_W-1:0] r;
        if (x > 40'sd32767) begin
            r = 16'sh7FFF;
        end else if (x < -40'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = x[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Serial multiply-accumulate for one output neuron. result_o reflects the
// accumulator's next value so the caller can register it on the same edge.
module fc_mac #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int FRAC_W = cnn_pkg::FRAC_W,
    parameter int ACC_W  = cnn_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     load_bias_i,
    input  logic                     acc_en_i,
    input  logic                     relu_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] result_o
);
    import cnn_pkg::*;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    shifted_s;
    logic signed [DATA_W-1:0]   sat_s;

    // Accumulator next value, then scale back to Q8.8, saturate and ReLU.
    always_comb begin
        prod_s = a_i * b_i;
        acc_d  = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_bias_i) begin
            acc_d = {{(ACC_W-DATA_W-FRAC_W){bias_i[DATA_W-1]}}, bias_i, {FRAC_W{1'b0}}};
        end else if (acc_en_i) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
        end else begin
            acc_d = acc_q;
        end
        shifted_s = acc_d >>> FRAC_W;
        sat_s     = sat16(shifted_s);
        if (relu_i && (sat_s < 16'sd0)) begin
            result_o = '0;
        end else begin
            result_o = sat_s;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc_layer.sv
// Fully connected layer: fetches the input vector and one weight row per
// neuron through load_block, runs a serial Q8.8 MAC and writes each result.
module fc_layer #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int FRAC_W = cnn_pkg::FRAC_W,
    parameter int ACC_W  = cnn_pkg::ACC_W,
    parameter int MAX_IN = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [15:0]              inSize,
    input  logic [15:0]              outSize,
    input  logic [15:0]              inAddress,
    input  logic [15:0]              weightsAddress,
    input  logic [15:0]              outAddress,
    input  logic                     reluEnable,
    input  logic                     loadDone,
    input  logic signed [DATA_W-1:0] loadOut [0:MAX_IN],
    output logic                     loadEnable,
    output logic [15:0]              loadAddr,
    output logic [15:0]              loadSize,
    output logic                     writeEnable,
    output logic [15:0]              writeAddr,
    output logic signed [DATA_W-1:0] writeOut,
    output logic                     done,
    output logic                     err
);
    import cnn_pkg::*;

    localparam int KW = $clog2(MAX_IN + 1);

    fc_state_t state_q, state_d;
    logic [15:0] in_size_q, in_size_d, out_size_q, out_size_d;
    logic [15:0] out_addr_q, out_addr_d, row_addr_q, row_addr_d, j_q, j_d;
    logic        relu_q, relu_d;
    logic [KW-1:0] k_q, k_d, k_last_s, k_plus_s;
    logic signed [DATA_W-1:0] vec_q [0:MAX_IN-1];

    logic        load_en_q, load_en_d, write_en_q, write_en_d;
    logic        done_q, done_d, err_q, err_d;
    logic [15:0] load_addr_q, load_addr_d, load_size_q, load_size_d;
    logic [15:0] write_addr_q, write_addr_d;
    logic signed [DATA_W-1:0] write_out_q, write_out_d;

    logic too_big_s, mac_clear_s, mac_load_s, mac_acc_s;
    logic signed [DATA_W-1:0] mac_result_s;

    assign too_big_s   = (inSize > 16'(MAX_IN));
    assign k_last_s    = in_size_q[KW-1:0] - KW'(1);
    assign k_plus_s    = k_q + KW'(1);
    assign mac_clear_s = (state_q == FC_IDLE);
    assign mac_load_s  = (state_q == FC_LOAD_ROW) && loadDone;
    assign mac_acc_s   = (state_q == FC_MAC);

    fc_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
        .clk        (clk),
        .rst_ni     (reset),
        .clear_i    (mac_clear_s),
        .load_bias_i(mac_load_s),
        .acc_en_i   (mac_acc_s),
        .relu_i     (relu_q),
        .bias_i     (loadOut[0]),
        .a_i        (vec_q[k_q]),
        .b_i        (loadOut[k_plus_s]),
        .result_o   (mac_result_s)
    );

    // Next state, configuration latch and j/k/row address counters.
    always_comb begin
        state_d    = state_q;
        in_size_d  = in_size_q;
        out_size_d = out_size_q;
        out_addr_d = out_addr_q;
        relu_d     = relu_q;
        row_addr_d = row_addr_q;
        j_d        = j_q;
        k_d        = k_q;
        case (state_q)
            FC_IDLE: begin
                if (enable) begin
                    in_size_d  = inSize;
                    out_size_d = outSize;
                    out_addr_d = outAddress;
                    relu_d     = reluEnable;
                    row_addr_d = weightsAddress;
                    j_d        = 16'd0;
                    if (too_big_s) begin
                        state_d = FC_FINISH;
                    end else if (outSize == 16'd0) begin
                        state_d = FC_FINISH;
                    end else begin
                        state_d = FC_LOAD_IN;
                    end
                end else begin
                    state_d = FC_IDLE;
                end
            end
            FC_LOAD_IN: begin
                if (loadDone) begin
                    state_d = FC_CAPTURE;
                end else begin
                    state_d = FC_LOAD_IN;
                end
            end
            FC_CAPTURE: state_d = FC_LOAD_ROW;
            FC_LOAD_ROW: begin
                if (loadDone) begin
                    k_d = '0;
                    if (in_size_q == 16'd0) begin
                        state_d = FC_WRITE;
                    end else begin
                        state_d = FC_MAC;
                    end
                end else begin
                    state_d = FC_LOAD_ROW;
                end
            end
            FC_MAC: begin
                k_d = k_plus_s;
                if (k_q == k_last_s) begin
                    state_d = FC_WRITE;
                end else begin
                    state_d = FC_MAC;
                end
            end
            FC_WRITE: state_d = FC_NEXT;
            FC_NEXT: begin
                j_d        = j_q + 16'd1;
                row_addr_d = row_addr_q + in_size_q + 16'd1;
                if (j_d == out_size_q) begin
                    state_d = FC_FINISH;
                end else begin
                    state_d = FC_LOAD_ROW;
                end
            end
            FC_FINISH: state_d = FC_FINISH;
            default:   state_d = FC_IDLE;
        endcase
        // Dropping enable aborts from any state.
        if (!enable) begin
            state_d = FC_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        load_en_d  = (state_d == FC_LOAD_IN) || (state_d == FC_LOAD_ROW) || (state_d == FC_MAC);
        write_en_d = (state_d == FC_WRITE);
        done_d     = (state_d == FC_FINISH);
        if (state_d == FC_FINISH) begin
            if (state_q == FC_IDLE) begin
                err_d = too_big_s;
            end else begin
                err_d = err_q;
            end
        end else begin
            err_d = 1'b0;
        end
        if ((state_d == FC_LOAD_IN) && (state_q == FC_IDLE)) begin
            load_addr_d = inAddress;
            load_size_d = inSize;
        end else if ((state_d == FC_LOAD_ROW) && (state_q != FC_LOAD_ROW)) begin
            load_addr_d = row_addr_d;
            load_size_d = in_size_q + 16'd1;
        end else begin
            load_addr_d = load_addr_q;
            load_size_d = load_size_q;
        end
        if (state_d == FC_WRITE) begin
            write_addr_d = out_addr_q + j_q;
            write_out_d  = mac_result_s;
        end else begin
            write_addr_d = write_addr_q;
            write_out_d  = write_out_q;
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FC_IDLE;
            in_size_q    <= 16'd0;
            out_size_q   <= 16'd0;
            out_addr_q   <= 16'd0;
            relu_q       <= 1'b0;
            row_addr_q   <= 16'd0;
            j_q          <= 16'd0;
            k_q          <= '0;
            load_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_addr_q  <= 16'd0;
            load_size_q  <= 16'd0;
            write_addr_q <= 16'd0;
            write_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_size_q    <= in_size_d;
            out_size_q   <= out_size_d;
            out_addr_q   <= out_addr_d;
            relu_q       <= relu_d;
            row_addr_q   <= row_addr_d;
            j_q          <= j_d;
            k_q          <= k_d;
            load_en_q    <= load_en_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            load_addr_q  <= load_addr_d;
            load_size_q  <= load_size_d;
            write_addr_q <= write_addr_d;
            write_out_q  <= write_out_d;
        end
    end

    // Input vector snapshot; pure datapath so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == FC_CAPTURE) begin
            for (int i = 0; i < MAX_IN; i++) begin
                vec_q[i] <= loadOut[i];
            end
        end
    end

    assign loadEnable  = load_en_q;
    assign loadAddr    = load_addr_q;
    assign loadSize    = load_size_q;
    assign writeEnable = write_en_q;
    assign writeAddr   = write_addr_q;
    assign writeOut    = write_out_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
